decoder_stream_sv: RTL and testbench

//  Streaming 4-to-10 decoder: binary code (0..9) -> 10-bit one-hot, the

---
 rtl/decoder_stream_sv.sv | 103 ++++++++++
 tb/tb_decoder_stream_sv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_stream_sv.sv
// Streaming 4-to-10 decoder with 2-entry output buffer.
// Illegal codes (10..15) are queued with an error flag and counted.
module decoder_stream_sv #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iVALID,
    input  logic [3:0]           iCODE,
    output logic                 oREADY,
    output logic                 oVALID,
    output logic [9:0]           oONEHOT,
    output logic                 oERR,
    input  logic                 iREADY,
    input  logic                 iCLR_CNT,
    output logic [ERR_CNT_W-1:0] oERR_CNT
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic                 ready_q;
    logic [10:0]          head;
    logic [10:0]          tail;
    logic [10:0]          dec;
    logic                 illegal;
    logic                 push;
    logic                 pop;
    logic [ERR_CNT_W-1:0] cnt;

    assign illegal = (iCODE > 4'd9);
    assign push    = iVALID & ready_q;
    assign pop     = (state != EMPTY) & iREADY;

    // Decode the incoming code into {err, onehot}
    always_comb begin
        dec = '0;
        if (illegal)
            dec[10] = 1'b1;
        else
            dec[9:0] = 10'd1 << iCODE;
    end

    // Buffer occupancy transitions
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)
                    state_next = FULL;
                else if (pop && !push)
                    state_next = EMPTY;
            end
            FULL:  if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Occupancy state and registered ready (low in FULL and during reset)
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != FULL);
        end
    end

    // Entry storage: head is always the oldest entry
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push && (state == EMPTY || (state == ONE && pop)))
                head <= dec;
            else if (pop && state == FULL)
                head <= tail;
            if (push && state == ONE && !pop)
                tail <= dec;
        end
    end

    // Saturating illegal-code counter; clear beats a same-cycle increment
    always_ff @(posedge iCLK) begin
        if (iRST || iCLR_CNT)
            cnt <= '0;
        else if (push && illegal && cnt != {ERR_CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end

    assign oREADY   = ready_q;
    assign oVALID   = (state != EMPTY);
    assign oONEHOT  = oVALID ? head[9:0] : 10'd0;
    assign oERR     = oVALID ? head[10] : 1'b0;
    assign oERR_CNT = cnt;

endmodule

// File: tb/tb_decoder_stream_sv.sv
// Self-checking bench for decoder_stream_sv: vector table,
// scoreboard on transfers, and directed corner-case sequences.
module tb_decoder_stream_sv;

    typedef struct {
        logic [3:0] code;
        logic [9:0] onehot;
        logic       err;
    } vec_t;

    typedef struct {
        logic [9:0] onehot;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld;
    logic [3:0] code;
    logic       rdy_out;
    logic       vld_out;
    logic [9:0] oh;
    logic       err;
    logic       rdy;
    logic       clr;
    logic [7:0] cnt;

    logic       vld2;
    logic [3:0] code2;
    logic       rdy_out2;
    logic       vld_out2;
    logic [9:0] oh2;
    logic       err2;
    logic       clr2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;
    vec_t tab[16];
    exp_t sb[$];

    always #5 clk = ~clk;

    decoder_stream_sv dut (
        .iCLK(clk), .iRST(rst), .iVALID(vld), .iCODE(code),
        .oREADY(rdy_out), .oVALID(vld_out), .oONEHOT(oh),
        .oERR(err), .iREADY(rdy), .iCLR_CNT(clr),
        .oERR_CNT(cnt)
    );

    decoder_stream_sv #(.ERR_CNT_W(2)) dut2 (
        .iCLK(clk), .iRST(rst), .iVALID(vld2), .iCODE(code2),
        .oREADY(rdy_out2), .oVALID(vld_out2), .oONEHOT(oh2),
        .oERR(err2), .iREADY(1'b1), .iCLR_CNT(clr2),
        .oERR_CNT(cnt2)
    );

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard: inputs are stable here and describe the next edge
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (vld_out && rdy) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_pop", 1, 0);
                end else begin
                    chk("sb_onehot", {22'd0, oh}, {22'd0, sb[0].onehot});
                    chk("sb_err", {31'd0, err}, {31'd0, sb[0].err});
                    void'(sb.pop_front());
                end
            end
            if (vld && rdy_out)
                sb.push_back('{tab[code].onehot, tab[code].err});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] exp3[2];
        for (int i = 0; i < 16; i++) begin
            tab[i].code   = 4'(i);
            tab[i].onehot = (i < 10) ? (10'd1 << i) : 10'd0;
            tab[i].err    = (i >= 10);
        end
        exp3[0] = 10'h040;
        exp3[1] = 10'h080;

        rst = 1; vld = 0; code = 0; rdy = 1; clr = 0;
        vld2 = 0; code2 = 0; clr2 = 0;
        step();
        chk("rst_valid", {31'd0, vld_out}, 0);
        chk("rst_onehot", {22'd0, oh}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_cnt", {24'd0, cnt}, 0);
        chk("rst_ready", {31'd0, rdy_out}, 0);
        rst = 0;
        step();
        chk("ready_after_rst", {31'd0, rdy_out}, 1);

        // 1: legal codes back-to-back, 1-cycle latency
        for (int i = 0; i < 10; i++) begin
            vld = 1; code = tab[i].code;
            step();
            chk("t1_valid", {31'd0, vld_out}, 1);
            chk("t1_onehot", {22'd0, oh}, {22'd0, tab[i].onehot});
            chk("t1_err", {31'd0, err}, {31'd0, tab[i].err});
        end
        vld = 0;
        step();
        chk("t1_drained", {31'd0, vld_out}, 0);
        chk("t1_cnt", {24'd0, cnt}, 0);

        // 2: illegal then legal
        vld = 1; code = 4'd12;
        step();
        chk("t2_err1", {31'd0, err}, 1);
        chk("t2_oh1", {22'd0, oh}, 0);
        code = 4'd3;
        step();
        chk("t2_err2", {31'd0, err}, 0);
        chk("t2_oh2", {22'd0, oh}, 10'h008);
        vld = 0;
        step();
        chk("t2_cnt", {24'd0, cnt}, 1);

        // don't-care code while idle
        code = 4'bxxxx;
        step();
        step();
        chk("x_valid", {31'd0, vld_out}, 0);
        chk("x_cnt", {24'd0, cnt}, 1);
        chk("x_ready", {31'd0, rdy_out}, 1);

        // 3: backpressure fills the buffer
        rdy = 0; vld = 1; code = 4'd5;
        step();
        chk("t3_ready1", {31'd0, rdy_out}, 1);
        code = 4'd6;
        step();
        chk("t3_full", {31'd0, rdy_out}, 0);
        code = 4'd7;
        step();
        step();
        chk("t3_hold_oh", {22'd0, oh}, 10'h020);
        chk("t3_hold_rdy", {31'd0, rdy_out}, 0);
        rdy = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t3_order", {22'd0, oh}, {22'd0, exp3[i]});
        end
        vld = 0;
        step();
        chk("t3_empty", {31'd0, vld_out}, 0);

        // 4: iREADY toggling, iVALID every cycle
        vld = 1;
        for (int i = 0; i < 60; i++) begin
            code = 4'($urandom_range(0, 15));
            rdy = i[0];
            step();
        end
        vld = 0; rdy = 1;
        for (int i = 0; i < 10 && vld_out; i++)
            step();
        chk("t4_drain_valid", {31'd0, vld_out}, 0);
        step();
        chk("t4_sb_empty", sb.size(), 0);

        // clear on the default-width counter
        clr = 1;
        step();
        clr = 0;
        chk("clr_cnt", {24'd0, cnt}, 0);

        // 5: 2-bit counter saturates, clear beats increment
        vld2 = 1; code2 = 4'd14;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_sat", {30'd0, cnt2}, (i < 3) ? i + 1 : 3);
        end
        clr2 = 1;
        step();
        chk("t5_clr", {30'd0, cnt2}, 0);
        clr2 = 0; vld2 = 0;
        step();
        chk("t5_after_clr", {30'd0, cnt2}, 0);

        // 6: reset while full
        rdy = 0; vld = 1; code = 4'd1;
        step();
        code = 4'd2;
        step();
        chk("t6_full", {31'd0, rdy_out}, 0);
        rst = 1;
        step();
        chk("t6_valid", {31'd0, vld_out}, 0);
        chk("t6_oh", {22'd0, oh}, 0);
        chk("t6_ready", {31'd0, rdy_out}, 0);
        rst = 0; vld = 0;
        step();
        chk("t6_ready_back", {31'd0, rdy_out}, 1);
        chk("t6_still_empty", {31'd0, vld_out}, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
